fifo_sync_param: RTL and testbench

- Parametrised synchronous FIFO; next generation of the 16x128 message-block FIFO between the host interface and the MD5 core.
- Adds the following over the earlier FIFO:
  - configurable width and depth;
  - full, empty and almost-full flags plus an occupancy count;
  - a read-data valid strobe;
  - true simultaneous read/write;
  - overflow and underflow protection with error pulses.
- Storage is an internal register array with a registered read port, so read latency is 1 cycle.

---
 rtl/fifo_sync_param.sv | 106 ++++++++++
 tb/tb_fifo_sync_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised synchronous FIFO. It buffers message blocks between the host
// interface and the MD5 core. Storage is a register array with a registered
// read port, so read data appears one cycle after an accepted read. A read
// and a write can be accepted in the same cycle. When the FIFO is full, a
// read frees a slot for a write in that same cycle. A write to a full FIFO
// or a read from an empty FIFO is rejected and raises a one-cycle error pulse.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   we_i, data_i   write request and write data
//   rd_i           read request
//   data_o         read data, holds its value between reads
//   valid_o        data_o carries a newly read entry this cycle
//   full_o         count_o == 2**AW
//   empty_o        count_o == 0
//   almost_full_o  count_o >= AFULL
//   count_o        occupancy, 0..2**AW
//   ovf_o          pulse: write rejected because the FIFO was full
//   udf_o          pulse: read rejected because the FIFO was empty
module fifo_sync_param #(
    parameter int DW    = 128,
    parameter int AW    = 4,
    parameter int AFULL = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [DW-1:0] data_i,
    input  logic          rd_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          almost_full_o,
    output logic [AW:0]   count_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int          DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_CNT = (AW+1)'(AFULL);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rdptr;
    logic [AW-1:0] wrptr;
    logic          rd_ok;
    logic          wr_ok;
    logic [AW:0]   count_next;

    // A read is accepted whenever there is data. A write is accepted when
    // there is room, or when a read in the same cycle frees a slot.
    assign rd_ok = rd_i & ~empty_o;
    assign wr_ok = we_i & (~full_o | rd_ok);

    // The flags are registered from the next count, so they always agree
    // with count_o in the cycle they are visible.
    always_comb begin
        count_next = count_o + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end

    // The storage array has no reset, because its contents are don't-care
    // until an entry is written. A reset cycle blocks writes so that reset
    // overrides we_i. When the FIFO is full and a read and a write occur
    // together, both target the same slot. The nonblocking read still returns
    // the old entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_ok) begin
            mem[wrptr] <= data_i;
        end
    end

    // Pointers, occupancy, read port and status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdptr         <= '0;
            wrptr         <= '0;
            count_o       <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            ovf_o         <= 1'b0;
            udf_o         <= 1'b0;
            full_o        <= 1'b0;
            empty_o       <= 1'b1;
            almost_full_o <= 1'b0;
        end else begin
            count_o       <= count_next;
            full_o        <= (count_next == DEPTH_CNT);
            empty_o       <= (count_next == '0);
            almost_full_o <= (count_next >= AFULL_CNT);
            valid_o       <= rd_ok;
            ovf_o         <= we_i & ~wr_ok;
            udf_o         <= rd_i & empty_o;
            if (wr_ok) begin
                wrptr <= wrptr + AW'(1);
            end
            if (rd_ok) begin
                rdptr  <= rdptr + AW'(1);
                data_o <= mem[rdptr];
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Self-checking bench for fifo_sync_param with its default parameters
// (128 x 16, almost-full threshold 12). A queue-based reference model
// predicts every output after every clock. The bench also includes a table
// of hand-written vectors, directed sequences for fill, drain, concurrent
// access, wrap-around and mid-stream reset, and a randomized phase.
module tb_fifo_sync_param;

    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic          clk_i;
    logic          rst_i;
    logic          we_i;
    logic [DW-1:0] data_i;
    logic          rd_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic [AW:0]   count_o;
    logic          ovf_o;
    logic          udf_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: the FIFO contents as a queue plus the last read word
    // and the pulse outputs expected after the most recent edge.
    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] mData  = '0;
    bit            mValid = 1'b0;
    bit            mOvf   = 1'b0;
    bit            mUdf   = 1'b0;

    typedef struct {
        bit            rst;
        bit            we;
        bit            rd;
        logic [DW-1:0] data;
        int            expCount;
        bit            expValid;
        logic [DW-1:0] expData;
        bit            expOvf;
        bit            expUdf;
    } vec_t;

    vec_t vecs[$];

    fifo_sync_param #(.DW(DW), .AW(AW), .AFULL(AFULL)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .we_i          (we_i),
        .data_i        (data_i),
        .rd_i          (rd_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .ovf_o         (ovf_o),
        .udf_o         (udf_o)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkVal(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput(input string label);
        int n;
        n = modelQ.size();
        checkVal({label, " count"}, DW'(count_o), DW'(n));
        checkVal({label, " empty"}, DW'(empty_o), DW'(n == 0));
        checkVal({label, " full"}, DW'(full_o), DW'(n == DEPTH));
        checkVal({label, " afull"}, DW'(almost_full_o), DW'(n >= AFULL));
        checkVal({label, " valid"}, DW'(valid_o), DW'(mValid));
        checkVal({label, " data"}, data_o, mData);
        checkVal({label, " ovf"}, DW'(ovf_o), DW'(mOvf));
        checkVal({label, " udf"}, DW'(udf_o), DW'(mUdf));
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic applyStimulus(input bit r, input bit w, input bit rd, input logic [DW-1:0] d, input string label);
        bit rdOk;
        bit wrOk;
        @(negedge clk_i);
        rst_i  = r;
        we_i   = w;
        rd_i   = rd;
        data_i = d;
        if (r) begin
            modelQ.delete();
            mData  = '0;
            mValid = 1'b0;
            mOvf   = 1'b0;
            mUdf   = 1'b0;
        end else begin
            rdOk   = rd && (modelQ.size() > 0);
            wrOk   = w && ((modelQ.size() < DEPTH) || rdOk);
            mValid = rdOk;
            mOvf   = w && !wrOk;
            mUdf   = rd && (modelQ.size() == 0);
            if (rdOk) mData = modelQ.pop_front();
            if (wrOk) modelQ.push_back(d);
        end
        @(posedge clk_i);
        #1;
        checkOutput(label);
    endtask

    function automatic void addVec(bit r, bit w, bit rd, logic [DW-1:0] d, int c, bit v, logic [DW-1:0] ed, bit o, bit u);
        vec_t t;
        t.rst = r; t.we = w; t.rd = rd; t.data = d;
        t.expCount = c; t.expValid = v; t.expData = ed; t.expOvf = o; t.expUdf = u;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [DW-1:0] gotQ[$];
        int            maxCount;

        rst_i  = 1'b1;
        we_i   = 1'b0;
        rd_i   = 1'b0;
        data_i = '0;

        // Reset, then idle.
        applyStimulus(1, 0, 0, '0, "reset");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, "idle");

        // Table vectors: empty concurrent access, then a mid-stream reset.
        addVec(1, 0, 0, 0,      0, 0, 0,      0, 0);
        addVec(0, 1, 1, 'h30,   1, 0, 0,      0, 1);
        addVec(0, 0, 1, 0,      0, 1, 'h30,   0, 0);
        addVec(0, 0, 0, 0,      0, 0, 'h30,   0, 0);
        for (int i = 1; i <= 9; i++) addVec(0, 1, 0, DW'('h40 + i), i, 0, 'h30, 0, 0);
        addVec(1, 1, 1, 'h99,   0, 0, 0,      0, 0);
        addVec(0, 1, 0, 'hA,    1, 0, 0,      0, 0);
        addVec(0, 0, 1, 0,      0, 1, 'hA,    0, 0);
        addVec(0, 0, 0, 0,      0, 0, 'hA,    0, 0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].rd, vecs[i].data, $sformatf("vec%0d", i));
            checkVal($sformatf("vec%0d tcount", i), DW'(count_o), DW'(vecs[i].expCount));
            checkVal($sformatf("vec%0d tvalid", i), DW'(valid_o), DW'(vecs[i].expValid));
            checkVal($sformatf("vec%0d tdata", i), data_o, vecs[i].expData);
            checkVal($sformatf("vec%0d tovf", i), DW'(ovf_o), DW'(vecs[i].expOvf));
            checkVal($sformatf("vec%0d tudf", i), DW'(udf_o), DW'(vecs[i].expUdf));
        end

        // Fill to full, then overflow.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 1, 0, DW'(k), $sformatf("fill%0d", k));
            checkVal($sformatf("fill%0d xcount", k), DW'(count_o), DW'(k));
            checkVal($sformatf("fill%0d xafull", k), DW'(almost_full_o), DW'(k >= 12));
            checkVal($sformatf("fill%0d xfull", k), DW'(full_o), DW'(k == 16));
        end
        applyStimulus(0, 1, 0, 'hFF, "ovf");
        checkVal("ovf xpulse", DW'(ovf_o), 1);
        checkVal("ovf xcount", DW'(count_o), 16);
        applyStimulus(0, 0, 0, '0, "ovf_end");
        checkVal("ovf_end xpulse", DW'(ovf_o), 0);

        // Drain, then underflow.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(0, 0, 1, '0, $sformatf("drain%0d", k));
            checkVal($sformatf("drain%0d xvalid", k), DW'(valid_o), 1);
            checkVal($sformatf("drain%0d xdata", k), data_o, DW'(k));
        end
        checkVal("drain xempty", DW'(empty_o), 1);
        applyStimulus(0, 0, 1, '0, "udf");
        checkVal("udf xpulse", DW'(udf_o), 1);
        checkVal("udf xvalid", DW'(valid_o), 0);
        checkVal("udf xdata", data_o, 'h10);

        // Concurrent read and write while full.
        for (int k = 1; k <= 16; k++) applyStimulus(0, 1, 0, DW'(k), "refill");
        applyStimulus(0, 1, 1, 'h20, "fullrw");
        checkVal("fullrw xovf", DW'(ovf_o), 0);
        checkVal("fullrw xcount", DW'(count_o), 16);
        checkVal("fullrw xdata", data_o, 'h1);
        for (int k = 0; k < 16; k++) applyStimulus(0, 0, 1, '0, "drain2");
        checkVal("drain2 xlast", data_o, 'h20);

        // Wrap-around stream: value k on cycle k, reads from cycle 3 onward.
        maxCount = 0;
        for (int k = 1; k <= 43; k++) begin
            applyStimulus(0, k <= 40, k >= 3, DW'(k), "stream");
            if (valid_o) gotQ.push_back(data_o);
            if (int'(count_o) > maxCount) maxCount = int'(count_o);
        end
        checkVal("stream xlen", DW'(gotQ.size()), 40);
        checkVal("stream xmaxcount", DW'(maxCount <= 3), 1);
        foreach (gotQ[i]) checkVal($sformatf("stream xword%0d", i), gotQ[i], DW'(i + 1));

        // Randomized traffic with alternating fill/drain bias and rare resets.
        for (int i = 0; i < 400; i++) begin
            int weBias;
            int rdBias;
            weBias = ((i / 50) % 2 == 0) ? 75 : 30;
            rdBias = ((i / 50) % 2 == 0) ? 35 : 75;
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 99) < weBias,
                          $urandom_range(0, 99) < rdBias,
                          {$urandom, $urandom, $urandom, $urandom},
                          $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
